// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer placed right after the UART receiver. Each rising
// edge of the receiver's data-ready strobe captures one word into a circular
// buffer. The head word is offered first-word-fall-through over valid/ready.
// Occupancy flags and a sticky overflow flag are decoded from registered state.

module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                       sysclk_in,
    input  logic                       nrst_in,
    input  logic                       wr_pulse_in,
    input  logic [DATA_BITS-1:0]       wr_data_in,
    output logic                       rd_valid_out,
    output logic [DATA_BITS-1:0]       rd_data_out,
    input  logic                       rd_ready_in,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic                       empty_out,
    output logic                       full_out,
    output logic                       overflow_out,
    input  logic                       ovf_clr_in
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic                 wr_pulse_q_r;
    logic                 armed_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 overflow_r;

    logic                 push_s;
    logic                 pop_s;
    logic                 empty_s;
    logic                 full_s;
    logic                 accept_s;
    logic                 drop_s;

    // Decode the handshake and occupancy conditions from registered state.
    // armed_r stays low after reset until the strobe has been seen low once,
    // so a strobe that was already high when reset released is not a rise.
    always_comb begin
        empty_s  = (count_r == CNT_ZERO);
        full_s   = (count_r == CNT_FULL);
        push_s   = wr_pulse_in & ~wr_pulse_q_r & armed_r;
        pop_s    = ~empty_s & rd_ready_in;
        // A pop in the same edge frees the slot, so a push at full still fits.
        accept_s = push_s & (~full_s | pop_s);
        drop_s   = push_s & full_s & ~pop_s;
    end

    // Strobe edge detector and its post-reset arming flag.
    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wr_pulse_q_r <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            wr_pulse_q_r <= wr_pulse_in;
            armed_r      <= armed_r | ~wr_pulse_in;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge sysclk_in) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= wr_data_in;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same edge as a clear keeps it set.
    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr_in) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Output decode: flags from the count register, head word gated by valid.
    always_comb begin
        empty_out    = empty_s;
        full_out     = full_s;
        rd_valid_out = ~empty_s;
        count_out    = count_r;
        overflow_out = overflow_r;
        if (!empty_s) begin
            rd_data_out = mem_r[rd_ptr_r];
        end else begin
            rd_data_out = {DATA_BITS{1'b0}};
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each received word on the rising edge of the receiver's data-ready strobe and stores it in a circular buffer. Words are presented to the consumer (register bank, bus bridge or DMA) over a first-word-fall-through valid/ready interface. The buffer also reports occupancy and raises a sticky overflow flag when a word arrives while the buffer is full.

## Interface
- DATA_BITS, 8, width of one received word; matches the receiver's DATA_BITS.
- DEPTH, 16, number of entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of count_out (derived localparam, not overridable).

- sysclk_in  in  1  system clock; all logic on rising edge.
- nrst_in  in  1  asynchronous active-low reset.
- wr_pulse_in  in  1  receiver data-ready strobe (connect to data_rdy_out).
- wr_data_in  in  DATA_BITS  received word (connect to rx_data_out); sampled on the accepted edge.
- rd_valid_out  out  1  head entry available.
- rd_data_out  out  DATA_BITS  head entry; all zeros when rd_valid_out=0.
- rd_ready_in  in  1  consumer accepts the head entry.
- count_out  out  CNT_W  number of stored entries, 0..DEPTH.
- empty_out  out  1  count_out==0.
- full_out  out  1  count_out==DEPTH.
- overflow_out  out  1  sticky: a word was dropped.
- ovf_clr_in  in  1  clears overflow_out.

## Operation
- Reset values:
  - wr_pulse_q=0, wr_ptr=0, rd_ptr=0, count=0, overflow_out=0.
  - Resulting outputs: rd_valid_out=0, rd_data_out=0, empty_out=1, full_out=0.
  - Memory array is not reset.
- Edge detect: push = wr_pulse_in & ~wr_pulse_q, where wr_pulse_q is wr_pulse_in registered.
  - A strobe held high for N cycles gives exactly one push.
  - A strobe already high when reset releases gives no push until it falls and rises again.
- Pop: pop = rd_valid_out & rd_ready_in. rd_ready_in is ignored when the buffer is empty.
- Write: when accepted, mem[wr_ptr] <= wr_data_in and wr_ptr <= wr_ptr+1. Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- Read: rd_data_out = mem[rd_ptr] gated by rd_valid_out (combinational). On pop, rd_ptr <= rd_ptr+1.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Full with simultaneous push and pop: the push is accepted, because the pop frees the slot in the same edge.
- Full with push and no pop:
  - Word dropped; wr_ptr and count unchanged.
  - overflow_out <= 1.
- Overflow clear: ovf_clr_in=1 clears overflow_out on the next edge. If an overflow push occurs in the same cycle, set wins and overflow_out stays 1.
- Derived flags: rd_valid_out = ~empty_out. empty_out and full_out are decoded from the count register.
- Reset mid-operation: all state clears asynchronously, stored words are discarded, and no spurious push occurs after release.

## Timing
- Push latency: a wr_pulse_in rise sampled at edge T is written at T. From after T: rd_valid_out=1 (if the buffer was empty), count_out incremented, and rd_data_out shows the word.
- Pop: handshake at edge T. From after T: the next entry is shown, or rd_valid_out=0 and rd_data_out=0 if the buffer is now empty.
- Back-to-back pops: rd_ready_in held high drains one word per cycle.
- Back-to-back pushes: limited by the strobe shape; minimum 2 cycles per push (rise, then fall).
- No combinational path from wr_pulse_in or wr_data_in to any output.
- rd_ready_in only affects state, not any output, within the same cycle.

## Test plan
- Reset, then a single strobe with wr_data_in=0xA5 -> the cycle after the edge shows rd_valid_out=1, rd_data_out=0xA5, count_out=1. One pop -> empty_out=1, rd_data_out=0x00.
- Strobe held high 5 cycles with data 0x3C -> exactly one entry, count_out=1.
- Fill the 16 entries 0x00..0x0F, then drain with rd_ready_in=1 continuously -> reads 0x00..0x0F in order, one per cycle. full_out=1 before draining; empty_out=1 after.
- At full, push 0xEE with no pop -> 0xEE dropped, overflow_out=1, count_out=16. Drain shows 0x00..0x0F only. Pulse ovf_clr_in -> overflow_out=0.
- At full, push 0x77 in the same cycle as a pop -> count_out stays 16, overflow_out=0, and 0x77 is the last word read. Additionally, ovf_clr_in coincident with an overflow push -> overflow_out stays 1.
- Push 10 words, pop 7, push 12 more (pointers wrap), assert nrst_in mid-stream -> before reset, order is preserved across the wrap. After reset: count_out=0, rd_valid_out=0, overflow_out=0, and a fresh strobe with 0x5A reads back 0x5A.
